// File: rtl/switch_debounce_pkg.sv
// Shared LED mode codes, used by the switch debouncer and the LED mode selector.
package switch_debounce_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON1   = 2'b01,
    MODE_ON2   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  localparam int MODE_W = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchroniser for asynchronous level inputs; resets to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/switch_debounce.sv
// Synchronises the raw switch bus and commits a new code only after it has
// held unchanged for DEBOUNCE_CYCLES clocks; the whole vector debounces as one.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sw_in,
  output logic [WIDTH-1:0] o_sw_out,
  output logic             o_sw_change
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]  RST_CODE = WIDTH'(MODE_OFF);

  typedef enum logic {IDLE, WAIT} state_e;

  logic [WIDTH-1:0] w_sync;
  state_e           r_state, w_nxt_state;
  logic [WIDTH-1:0] r_cand,  w_nxt_cand;
  logic [CNT_W-1:0] r_cnt,   w_nxt_cnt;
  logic [WIDTH-1:0] r_sw_out, w_nxt_out;
  logic             r_change, w_nxt_change;

  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_sw_in),
    .o_q   (w_sync)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_sw_out <= RST_CODE;
      r_change <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cand   <= w_nxt_cand;
      r_cnt    <= w_nxt_cnt;
      r_sw_out <= w_nxt_out;
      r_change <= w_nxt_change;
    end
  end

  // Any code differing from the candidate restarts the count at 1, so a
  // skewed multi-bit change only ever commits its final settled code.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cand   = r_cand;
    w_nxt_cnt    = r_cnt;
    w_nxt_out    = r_sw_out;
    w_nxt_change = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sync != r_sw_out) begin
          w_nxt_cand  = w_sync;
          w_nxt_cnt   = CNT_ONE;
          w_nxt_state = WAIT;
        end else begin
          w_nxt_cnt = '0;
        end
      end
      WAIT: begin
        if (w_sync == r_cand) begin
          if (r_cnt == CNT_LAST) begin
            w_nxt_out    = r_cand;
            w_nxt_change = 1'b1;
            w_nxt_cnt    = '0;
            w_nxt_state  = IDLE;
          end else begin
            w_nxt_cnt = r_cnt + CNT_ONE;
          end
        end else if (w_sync == r_sw_out) begin
          w_nxt_cnt   = '0;
          w_nxt_state = IDLE;
        end else begin
          w_nxt_cand = w_sync;
          w_nxt_cnt  = CNT_ONE;
        end
      end
      default: begin
        w_nxt_cnt   = '0;
        w_nxt_state = IDLE;
      end
    endcase
  end

  assign o_sw_out    = r_sw_out;
  assign o_sw_change = r_change;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=8 (commit on edge 10).
module tb_switch_debounce;
  import switch_debounce_pkg::*;

  localparam int W = 2;

  logic         i_clk;
  logic         i_rst;
  logic [W-1:0] i_sw_in;
  logic [W-1:0] o_sw_out;
  logic         o_sw_change;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] model_out;

  typedef struct {
    string        name;
    logic [W-1:0] sw;
    int           edges;
    int           commit;   // edge of commit, 0 = none expected
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t tbl[4];

  switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sw_in     (i_sw_in),
    .o_sw_out    (o_sw_out),
    .o_sw_change (o_sw_change)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // Drive sw, then check out/change on each of the next 'edges' rising edges.
  task automatic run_seg(input string nm, input logic [W-1:0] sw, input int edges,
                         input int commit, input logic [W-1:0] exp);
    logic [W-1:0] eo;
    i_sw_in = sw;
    for (int e = 1; e <= edges; e++) begin
      tick();
      eo = (commit != 0 && e >= commit) ? exp : model_out;
      chk($sformatf("%s e%0d out", nm, e), o_sw_out, eo);
      chk($sformatf("%s e%0d chg", nm, e), {1'b0, o_sw_change}, {1'b0, (e == commit)});
    end
    if (commit != 0) model_out = exp;
  endtask

  initial begin
    tbl[0] = '{"rst_rel", MODE_BLINK, 12, 10, MODE_BLINK};
    tbl[1] = '{"to_off",  MODE_OFF,   12, 10, MODE_OFF};
    tbl[2] = '{"clean",   MODE_ON2,   12, 10, MODE_ON2};
    tbl[3] = '{"to_off2", MODE_OFF,   12, 10, MODE_OFF};
    model_out = MODE_OFF;

    // Reset held with all switches up
    i_rst   = 1'b1;
    i_sw_in = MODE_BLINK;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("in_rst%0d out", i), o_sw_out, MODE_OFF);
      chk($sformatf("in_rst%0d chg", i), {1'b0, o_sw_change}, 2'b00);
    end
    i_rst = 1'b0;

    for (int v = 0; v < 4; v++)
      run_seg(tbl[v].name, tbl[v].sw, tbl[v].edges, tbl[v].commit, tbl[v].exp_out);

    // Bounce: 01/00 toggling every 3 cycles never commits, then hold 01
    for (int s = 0; s < 10; s++)
      run_seg($sformatf("bounce%0d", s), (s % 2 == 0) ? MODE_ON1 : MODE_OFF, 3, 0, MODE_OFF);
    run_seg("bounce_hold", MODE_ON1, 12, 10, MODE_ON1);

    // Skewed change 01->11->10: 11 is never committed
    run_seg("skew11", MODE_BLINK, 2, 0, MODE_ON1);
    run_seg("skew10", MODE_ON2, 14, 10, MODE_ON2);

    // Async reset mid-cycle clears sw_out without a clock edge
    #3;
    i_rst   = 1'b1;
    i_sw_in = MODE_OFF;
    #1;
    chk("async_rst out", o_sw_out, MODE_OFF);
    chk("async_rst chg", {1'b0, o_sw_change}, 2'b00);
    model_out = MODE_OFF;
    tick();
    tick();
    i_rst = 1'b0;

    // Glitch to 11 for 4 cycles, back to 00: no commit, no pulse
    run_seg("glitch11", MODE_BLINK, 4, 0, MODE_OFF);
    run_seg("glitch00", MODE_OFF, 15, 0, MODE_OFF);

    // Reset mid-WAIT discards the candidate; commit counts from release
    run_seg("wait_pre", MODE_ON1, 5, 0, MODE_OFF);
    i_rst = 1'b1;
    #1;
    chk("midwait_rst out", o_sw_out, MODE_OFF);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("midwait_in_rst%0d out", i), o_sw_out, MODE_OFF);
      chk($sformatf("midwait_in_rst%0d chg", i), {1'b0, o_sw_change}, 2'b00);
    end
    i_rst = 1'b0;
    run_seg("midwait_rel", MODE_ON1, 12, 10, MODE_ON1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
